// File: rtl/sram_req_responder.sv
// In-order SRAM request responder: queues rd_0/wr_0 pulses and executes them against an on-chip RAM.
// Optional macro SRAM_RESP_STATS_EN builds the rd_cnt/wr_cnt statistics counters.
module sram_req_responder #(
    parameter int DATA_WIDTH      = 64,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int RD_LATENCY      = 2,
    parameter int Q_DEPTH_BITS    = 3,
    parameter int TURNAROUND      = 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_rd_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] i_rd_0_addr,
    output logic                       o_rd_0_ack,
    output logic                       o_rd_0_vld,
    output logic [DATA_WIDTH-1:0]      o_rd_0_data,
    input  logic                       i_wr_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] i_wr_0_addr,
    input  logic [DATA_WIDTH-1:0]      i_wr_0_data,
    output logic                       o_wr_0_ack,
    output logic [15:0]                o_drop_cnt,
    output logic                       o_q_empty,
    output logic [15:0]                o_rd_cnt,
    output logic [15:0]                o_wr_cnt
);
    localparam int QD = 1 << Q_DEPTH_BITS;
    localparam int QB = Q_DEPTH_BITS;
    localparam int CW = Q_DEPTH_BITS + 2;
    localparam logic [1:0] TA_M1 = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

    typedef struct packed {
        logic                      is_wr;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
    } q_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;

    q_entry_t                  r_q [QD];
    logic [QB-1:0]             r_wptr, r_rptr;
    logic [QB:0]               r_count;
    logic                      r_skid_v;
    logic [MEM_ADDR_WIDTH-1:0] r_skid_addr;
    state_t                    r_state, w_state_nxt;
    logic [1:0]                r_turn_cnt, w_turn_cnt_nxt;
    logic [15:0]               r_drop_cnt;
    logic [DATA_WIDTH-1:0]     r_mem [1 << MEM_ADDR_WIDTH];
    logic [RD_LATENCY:1]       r_vld_pipe;
    logic [DATA_WIDTH-1:0]     r_dpipe [1:RD_LATENCY];

    q_entry_t    w_head, w_skid_e, w_wr_e, w_rd_e, w_e0, w_e1;
    logic        w_head_v, w_issue, w_issue_rd, w_issue_wr;
    logic [CW-1:0] w_room;
    logic        w_push_skid, w_push_wr, w_push_rd, w_skid_load;
    logic [1:0]  w_drop_inc, w_n_push;
    logic [16:0] w_drop_sum;
    logic        w_unused;

    assign w_head     = r_q[r_rptr];
    assign w_head_v   = (r_count != '0);
    assign w_issue_rd = w_issue & ~w_head.is_wr;
    assign w_issue_wr = w_issue & w_head.is_wr;
    assign w_unused   = ^{i_rd_0_addr[SRAM_ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                          i_wr_0_addr[SRAM_ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

    // Issue/turnaround FSM; nothing issues while reset is asserted so queued work is discarded.
    always_comb begin
        w_state_nxt    = r_state;
        w_turn_cnt_nxt = r_turn_cnt;
        w_issue        = 1'b0;
        if (i_reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_head_v) begin
                        w_issue     = 1'b1;
                        w_state_nxt = w_head.is_wr ? S_WRITE : S_READ;
                    end
                end
                S_READ, S_WRITE: begin
                    if (!w_head_v) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_head.is_wr == (r_state == S_WRITE)) begin
                        w_issue = 1'b1;
                    end else if (TURNAROUND > 0) begin
                        w_state_nxt    = S_TURN;
                        w_turn_cnt_nxt = TA_M1;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = w_head.is_wr ? S_WRITE : S_READ;
                    end
                end
                default: begin
                    if (r_turn_cnt != 2'd0) begin
                        w_turn_cnt_nxt = r_turn_cnt - 2'd1;
                    end else if (w_head_v) begin
                        w_issue     = 1'b1;
                        w_state_nxt = w_head.is_wr ? S_WRITE : S_READ;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end
    end

    // Enqueue arbitration: skid read first, then write, then read; a same-cycle pop frees a slot.
    always_comb begin
        w_room      = CW'(QD) - CW'(r_count) + CW'(w_issue);
        w_push_skid = 1'b0;
        w_push_wr   = 1'b0;
        w_push_rd   = 1'b0;
        w_skid_load = 1'b0;
        w_drop_inc  = 2'd0;
        if (r_skid_v && w_room != '0) begin
            w_push_skid = 1'b1;
            w_room      = w_room - CW'(1);
        end
        if (i_wr_0_req) begin
            if (w_room != '0) begin
                w_push_wr = 1'b1;
                w_room    = w_room - CW'(1);
            end else begin
                w_drop_inc = w_drop_inc + 2'd1;
            end
        end
        if (i_rd_0_req) begin
            if (i_wr_0_req) begin
                if (!r_skid_v || w_push_skid) w_skid_load = 1'b1;
                else                          w_drop_inc  = w_drop_inc + 2'd1;
            end else if (w_room != '0) begin
                w_push_rd = 1'b1;
            end else begin
                w_drop_inc = w_drop_inc + 2'd1;
            end
        end
    end

    assign w_skid_e   = {1'b0, r_skid_addr, {DATA_WIDTH{1'b0}}};
    assign w_wr_e     = {1'b1, i_wr_0_addr[MEM_ADDR_WIDTH-1:0], i_wr_0_data};
    assign w_rd_e     = {1'b0, i_rd_0_addr[MEM_ADDR_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
    assign w_e0       = w_push_skid ? w_skid_e : (w_push_wr ? w_wr_e : w_rd_e);
    assign w_e1       = w_push_wr ? w_wr_e : w_rd_e;
    assign w_n_push   = {1'b0, w_push_skid} + {1'b0, w_push_wr} + {1'b0, w_push_rd};
    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_inc);

    always_ff @(posedge i_clk) begin
        if (w_n_push != 2'd0) r_q[r_wptr] <= w_e0;
        if (w_n_push == 2'd2) r_q[r_wptr + QB'(1)] <= w_e1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_turn_cnt  <= 2'd0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_skid_v    <= 1'b0;
            r_skid_addr <= '0;
            r_drop_cnt  <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
            r_wptr     <= r_wptr + QB'(w_n_push);
            r_rptr     <= r_rptr + QB'(w_issue);
            r_count    <= r_count + (QB+1)'(w_n_push) - (QB+1)'(w_issue);
            if (w_skid_load) begin
                r_skid_v    <= 1'b1;
                r_skid_addr <= i_rd_0_addr[MEM_ADDR_WIDTH-1:0];
            end else if (w_push_skid) begin
                r_skid_v <= 1'b0;
            end
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_issue_wr) r_mem[w_head.addr] <= w_head.data;
    end

    // Data stages only advance behind a valid, so the output stage holds its last word.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_vld_pipe <= '0;
            for (int k = 1; k <= RD_LATENCY; k++) r_dpipe[k] <= '0;
        end else begin
            r_vld_pipe[1] <= w_issue_rd;
            if (w_issue_rd) r_dpipe[1] <= r_mem[w_head.addr];
            for (int k = 2; k <= RD_LATENCY; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                if (r_vld_pipe[k-1]) r_dpipe[k] <= r_dpipe[k-1];
            end
        end
    end

    assign o_rd_0_ack  = w_issue_rd;
    assign o_wr_0_ack  = w_issue_wr;
    assign o_rd_0_vld  = r_vld_pipe[RD_LATENCY];
    assign o_rd_0_data = r_dpipe[RD_LATENCY];
    assign o_drop_cnt  = r_drop_cnt;
    assign o_q_empty   = (r_count == '0) && !r_skid_v && (r_vld_pipe == '0);

`ifdef SRAM_RESP_STATS_EN
    logic [15:0] r_rd_cnt, r_wr_cnt;
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else begin
            if (o_rd_0_vld) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_issue_wr) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end
    assign o_rd_cnt = r_rd_cnt;
    assign o_wr_cnt = r_wr_cnt;
`else
    assign o_rd_cnt = 16'd0;
    assign o_wr_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_sram_req_responder.sv
// Self-checking bench for sram_req_responder: vector table, directed corner sequences and a
// randomized phase scored against an in-order queue/shadow-memory reference.
module tb_sram_req_responder;
    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        i_reset, i_rd_0_req, i_wr_0_req;
    logic [18:0] i_rd_0_addr, i_wr_0_addr;
    logic [63:0] i_wr_0_data, o_rd_0_data;
    logic        o_rd_0_ack, o_rd_0_vld, o_wr_0_ack, o_q_empty;
    logic [15:0] o_drop_cnt, o_rd_cnt, o_wr_cnt;

    always #5 clk = ~clk;

    sram_req_responder #(
        .DATA_WIDTH(64), .SRAM_ADDR_WIDTH(19), .MEM_ADDR_WIDTH(10),
        .RD_LATENCY(RDL), .Q_DEPTH_BITS(3), .TURNAROUND(1)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_rd_0_req(i_rd_0_req), .i_rd_0_addr(i_rd_0_addr),
        .o_rd_0_ack(o_rd_0_ack), .o_rd_0_vld(o_rd_0_vld), .o_rd_0_data(o_rd_0_data),
        .i_wr_0_req(i_wr_0_req), .i_wr_0_addr(i_wr_0_addr), .i_wr_0_data(i_wr_0_data),
        .o_wr_0_ack(o_wr_0_ack), .o_drop_cnt(o_drop_cnt), .o_q_empty(o_q_empty),
        .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt)
    );

    int checks = 0, failures = 0, cyc = 0;
    int n_wr_ack, n_rd_ack, n_vld, first_wr, first_rd, first_vld;
    logic [63:0] last_data;
    bit last_qe, mon_en = 1'b0;

    typedef struct { bit is_wr; logic [9:0] a; logic [63:0] d; } op_t;
    typedef struct { int due; logic [63:0] d; bit known; } pend_t;
    typedef struct { bit is_wr; logic [18:0] addr; logic [63:0] wdata; logic [63:0] exp; } vec_t;
    op_t   exp_q[$];
    pend_t pend_q[$];
    logic [63:0] shadow [1024];
    bit          known  [1024];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_cnt();
        n_wr_ack = 0; n_rd_ack = 0; n_vld = 0;
        first_wr = -1; first_rd = -1; first_vld = -1;
    endtask

    // One clock: sample at negedge, score against the reference, step past the next posedge.
    task automatic tick();
        bit ok;
        op_t o;
        pend_t p;
        @(negedge clk);
        last_qe = o_q_empty;
        if (o_wr_0_ack) begin n_wr_ack++; if (first_wr < 0) first_wr = cyc; end
        if (o_rd_0_ack) begin n_rd_ack++; if (first_rd < 0) first_rd = cyc; end
        if (o_rd_0_vld) begin n_vld++; last_data = o_rd_0_data; if (first_vld < 0) first_vld = cyc; end
        if (mon_en) begin
            if (o_wr_0_ack || o_rd_0_ack) chk("one_op_per_cycle", 64'(o_wr_0_ack & o_rd_0_ack), 0);
            if (o_wr_0_ack) begin
                ok = exp_q.size() > 0 && exp_q[0].is_wr;
                chk("rand_wr_order", 64'(ok), 1);
                if (ok) begin o = exp_q.pop_front(); shadow[o.a] = o.d; known[o.a] = 1'b1; end
            end
            if (o_rd_0_ack) begin
                ok = exp_q.size() > 0 && !exp_q[0].is_wr;
                chk("rand_rd_order", 64'(ok), 1);
                if (ok) begin
                    o = exp_q.pop_front();
                    p.due = cyc + RDL; p.d = shadow[o.a]; p.known = known[o.a];
                    pend_q.push_back(p);
                end
            end
            if (o_rd_0_vld) begin
                ok = pend_q.size() > 0 && pend_q[0].due == cyc;
                chk("rand_vld_timing", 64'(ok), 1);
                if (ok) begin
                    p = pend_q.pop_front();
                    if (p.known) chk("rand_rd_data", o_rd_0_data, p.d);
                end
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                chk("rand_vld_missing", 64'(o_rd_0_vld), 1);
                void'(pend_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit wr, input logic [18:0] wa, input logic [63:0] wd,
                         input bit rd, input logic [18:0] ra);
        i_wr_0_req = wr; i_wr_0_addr = wa; i_wr_0_data = wd;
        i_rd_0_req = rd; i_rd_0_addr = ra;
        if (mon_en) begin
            if (wr) exp_q.push_back('{1'b1, wa[9:0], wd});
            if (rd) exp_q.push_back('{1'b0, ra[9:0], 64'd0});
        end
        tick();
        i_wr_0_req = 1'b0; i_rd_0_req = 1'b0;
    endtask

    task automatic wait_idle(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            tick();
            if (last_qe) break;
        end
        chk(nm, 64'(last_qe), 1);
        tick(); tick();
    endtask

    task automatic op(input bit wr, input logic [18:0] a, input logic [63:0] d);
        clr_cnt();
        drive(wr, a, d, !wr, a);
        repeat (12) tick();
    endtask

    vec_t vt[8];

    initial begin
        int t0, first, dd;
        logic [15:0] d0, w0, r0;
        logic [18:0] wa, ra;
        i_reset = 1'b0; i_rd_0_req = 1'b0; i_wr_0_req = 1'b0;
        i_rd_0_addr = '0; i_wr_0_addr = '0; i_wr_0_data = '0;
        clr_cnt();
        repeat (3) tick();
        i_reset = 1'b1;
        chk("reset_rd_ack",  64'(o_rd_0_ack), 0);
        chk("reset_rd_vld",  64'(o_rd_0_vld), 0);
        chk("reset_rd_data", o_rd_0_data, 0);
        chk("reset_wr_ack",  64'(o_wr_0_ack), 0);
        chk("reset_q_empty", 64'(o_q_empty), 1);
        chk("reset_drop",    64'(o_drop_cnt), 0);
        chk("reset_rd_cnt",  64'(o_rd_cnt), 0);
        chk("reset_wr_cnt",  64'(o_wr_cnt), 0);

        // Vector table: single ops with boundary and aliased addresses.
        vt[0] = '{1'b1, 19'h00000, 64'h1111_2222_3333_4444, 64'h0};
        vt[1] = '{1'b1, 19'h003FF, 64'hFFFF_0000_FFFF_0000, 64'h0};
        vt[2] = '{1'b0, 19'h003FF, 64'h0, 64'hFFFF_0000_FFFF_0000};
        vt[3] = '{1'b1, 19'h00400, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
        vt[4] = '{1'b0, 19'h00000, 64'h0, 64'hDEAD_BEEF_CAFE_F00D};
        vt[5] = '{1'b0, 19'h7FFFF, 64'h0, 64'hFFFF_0000_FFFF_0000};
        vt[6] = '{1'b1, 19'h12345, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0};
        vt[7] = '{1'b0, 19'h00345, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0};
        for (int v = 0; v < 8; v++) begin
            op(vt[v].is_wr, vt[v].addr, vt[v].wdata);
            if (vt[v].is_wr) begin
                chk($sformatf("vec%0d_wr_ack", v), 64'(n_wr_ack), 1);
                chk($sformatf("vec%0d_no_rd", v), 64'(n_rd_ack + n_vld), 0);
            end else begin
                chk($sformatf("vec%0d_rd_ack", v), 64'(n_rd_ack), 1);
                chk($sformatf("vec%0d_vld", v), 64'(n_vld), 1);
                chk($sformatf("vec%0d_data", v), last_data, vt[v].exp);
                chk($sformatf("vec%0d_latency", v), 64'(first_vld - first_rd), RDL);
            end
        end

        // Write then read same address on the next cycle: turnaround bubble timing.
        clr_cnt(); t0 = cyc;
        drive(1'b1, 19'd5, 64'h0123_4567_89AB_CDEF, 1'b0, 19'd0);
        drive(1'b0, 19'd0, 64'd0, 1'b1, 19'd5);
        repeat (10) tick();
        chk("rw_wr_ack_cyc", 64'(first_wr - t0), 1);
        chk("rw_rd_ack_cyc", 64'(first_rd - t0), 3);
        chk("rw_vld_cyc",    64'(first_vld - t0), 5);
        chk("rw_data",       last_data, 64'h0123_4567_89AB_CDEF);

        // Simultaneous read and write to the same address.
        clr_cnt();
        drive(1'b1, 19'd7, 64'hAA, 1'b1, 19'd7);
        repeat (12) tick();
        chk("pair_wr_acks", 64'(n_wr_ack), 1);
        chk("pair_rd_acks", 64'(n_rd_ack), 1);
        chk("pair_order",   64'(first_wr < first_rd), 1);
        chk("pair_data",    last_data, 64'hAA);

        // Twelve back-to-back reads.
        d0 = o_drop_cnt; clr_cnt();
        for (int i = 0; i < 12; i++) drive(1'b0, 19'd0, 64'd0, 1'b1, 19'(i));
        wait_idle(80, "burst12_drain");
        chk("burst12_drop", 64'(o_drop_cnt - d0), 64'(12 - n_rd_ack));
        chk("burst12_vld",  64'(n_vld), 64'(n_rd_ack));
        chk("burst12_min",  64'(n_rd_ack >= 8), 1);

        // Alternating pairs outrun the turnaround-limited drain and overflow the queue.
        d0 = o_drop_cnt; clr_cnt();
        for (int i = 0; i < 12; i++) drive(1'b1, 19'(i + 32), 64'(i), 1'b1, 19'(i + 32));
        wait_idle(150, "flood_drain");
        dd = int'(o_drop_cnt) - int'(d0);
        chk("flood_conserve", 64'(dd + n_wr_ack + n_rd_ack), 24);
        chk("flood_dropped",  64'(dd > 0), 1);
        chk("flood_vld",      64'(n_vld), 64'(n_rd_ack));

        // Randomized bursts scored against the reference queue/shadow memory.
        d0 = o_drop_cnt; mon_en = 1'b1;
        for (int b = 0; b < 40; b++) begin
            int n, kind;
            clr_cnt(); t0 = cyc;
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                kind = $urandom_range(0, 3);
                if (kind == 3 && j == 0) kind = 0;
                wa = 19'($urandom); wa[9:0] = 10'($urandom_range(0, 15));
                ra = 19'($urandom); ra[9:0] = 10'($urandom_range(0, 15));
                case (kind)
                    0: drive(1'b0, wa, 64'd0, 1'b1, ra);
                    1: drive(1'b1, wa, {$urandom, $urandom}, 1'b0, ra);
                    2: drive(1'b1, wa, {$urandom, $urandom}, 1'b1, ra);
                    default: tick();
                endcase
            end
            wait_idle(60, "rand_drain");
            if (first_wr < 0)      first = first_rd;
            else if (first_rd < 0) first = first_wr;
            else                   first = (first_wr < first_rd) ? first_wr : first_rd;
            chk("rand_issue_latency", 64'(first - t0), 1);
        end
        mon_en = 1'b0;
        chk("rand_exp_empty",  64'(exp_q.size()), 0);
        chk("rand_pend_empty", 64'(pend_q.size()), 0);
        chk("rand_no_drops",   64'(o_drop_cnt - d0), 0);

        // Reset with reads in flight and a write still queued.
        op(1'b1, 19'h44, 64'h0_1D0_1D0_1D);
        drive(1'b0, 19'd0, 64'd0, 1'b1, 19'd1);
        drive(1'b0, 19'd0, 64'd0, 1'b1, 19'd2);
        drive(1'b0, 19'd0, 64'd0, 1'b1, 19'd3);
        drive(1'b1, 19'h44, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 19'd0);
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        chk("midrst_q_empty", 64'(o_q_empty), 1);
        chk("midrst_drop",    64'(o_drop_cnt), 0);
        chk("midrst_data",    o_rd_0_data, 0);
        clr_cnt();
        repeat (10) tick();
        chk("midrst_no_vld", 64'(n_vld + n_rd_ack + n_wr_ack), 0);
        chk("midrst_idle",   64'(o_q_empty), 1);
        op(1'b0, 19'h44, 64'd0);
        chk("midrst_ram_kept", last_data, 64'h0_1D0_1D0_1D);

        // Statistics counters.
        w0 = o_wr_cnt; r0 = o_rd_cnt;
        for (int i = 0; i < 3; i++) op(1'b1, 19'(100 + i), 64'(i));
        for (int i = 0; i < 2; i++) op(1'b0, 19'(100 + i), 64'd0);
`ifdef SRAM_RESP_STATS_EN
        chk("stats_wr_cnt", 64'(o_wr_cnt - w0), 3);
        chk("stats_rd_cnt", 64'(o_rd_cnt - r0), 2);
`else
        chk("stats_wr_cnt", 64'(o_wr_cnt | w0), 0);
        chk("stats_rd_cnt", 64'(o_rd_cnt | r0), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
